// File: rtl/rf_wb_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned NUM_REGS    = 32;
  localparam int unsigned DEF_NUM_REQ = 3;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  // Base bit index of slice idx within a packed per-requester vector.
  function automatic int unsigned slice_base(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester bus, register-file write pins and scoreboard query signals.
interface rf_wb_arbiter_if
  import rf_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                          stall_en;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          rf_wr_en;
  logic [REG_ADDR_W-1:0]         rf_wr_addr;
  logic [DATA_WIDTH-1:0]         rf_wr_data;

  logic                          claim_valid;
  logic [REG_ADDR_W-1:0]         claim_addr;
  logic [REG_ADDR_W-1:0]         chk_addr1;
  logic [REG_ADDR_W-1:0]         chk_addr2;
  logic                          busy1;
  logic                          busy2;
  logic                          any_busy;

  modport master (
    output stall_en, req_valid, req_addr, req_data, claim_valid, claim_addr, chk_addr1, chk_addr2,
    input  req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, busy1, busy2, any_busy
  );

  modport slave (
    input  stall_en, req_valid, req_addr, req_data, claim_valid, claim_addr, chk_addr1, chk_addr2,
    output req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, busy1, busy2, any_busy
  );

endinterface

// File: rtl/rf_wb_rr_select.sv
// Combinational one-hot selector: first valid requester at or after i_ptr, wrapping.
module rf_wb_rr_select #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = 2
) (
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((32'(i_ptr) + k) % NUM_REQ);
      if (i_en && !w_found && i_valid[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
// Define RF_WB_ROUND_ROBIN_EN for round-robin grants; otherwise lowest index wins.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ
) (
  input logic           clk,
  input logic           rst_n,
  rf_wb_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_any_grant;
  logic [PTR_W-1:0]      w_ptr;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic [REG_ADDR_W-1:0] w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic [NUM_REGS-1:0]   w_sb_d;

  logic                  r_wr_en;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [NUM_REGS-1:0]   r_sb;

  rf_wb_rr_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_select (
    .i_en    (!bus.stall_en),
    .i_valid (bus.req_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_grant)
  );

  assign w_any_grant = |w_grant;

`ifdef RF_WB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_any_grant) begin
      r_ptr <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`else
  // A fixed zero start point turns the wrapping search into lowest-index priority.
  assign w_ptr = '0;
`endif

  always_comb begin
    w_gnt_idx  = '0;
    w_gnt_addr = '0;
    w_gnt_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx  = PTR_W'(i);
        w_gnt_addr = bus.req_addr[slice_base(i, REG_ADDR_W) +: REG_ADDR_W];
        w_gnt_data = bus.req_data[slice_base(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  // Claim is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    w_sb_d = r_sb;
    if (w_any_grant) begin
      w_sb_d[w_gnt_addr] = 1'b0;
    end
    if (bus.claim_valid) begin
      w_sb_d[bus.claim_addr] = 1'b1;
    end
    w_sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_sb      <= '0;
    end else begin
      r_sb <= w_sb_d;
      if (w_any_grant) begin
        r_wr_en   <= (w_gnt_addr != REG_X0);
        r_wr_addr <= w_gnt_addr;
        r_wr_data <= w_gnt_data;
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = w_grant;
  assign bus.rf_wr_en   = r_wr_en;
  assign bus.rf_wr_addr = r_wr_addr;
  assign bus.rf_wr_data = r_wr_data;
  assign bus.busy1      = r_sb[bus.chk_addr1];
  assign bus.busy2      = r_sb[bus.chk_addr2];
  assign bus.any_busy   = |r_sb;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rf_wb_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  rf_wb_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_ptr;
  logic [31:0] m_sb;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        keep_valid;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Grant by rule: among valid requesters, the one nearest the pointer going upward (RR),
  // or simply the lowest index (fixed priority).
  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    int best;
    int d;
    g    = '0;
    best = N;
    if (!bus.stall_en) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i]) begin
`ifdef RF_WB_ROUND_ROBIN_EN
          d = (i - m_ptr + N) % N;
`else
          d = i;
`endif
          if (d < best) begin
            best = d;
            g    = '0;
            g[i] = 1'b1;
          end
        end
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_sb   = '0;
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic clear_inputs();
    bus.stall_en    = 1'b0;
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.claim_valid = 1'b0;
    bus.claim_addr  = '0;
    bus.chk_addr1   = '0;
    bus.chk_addr2   = '0;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_valid[i]       = 1'b1;
    bus.req_addr[i*5 +: 5] = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  // One clock: check combinational outputs, advance model at the edge, check registered outputs.
  task automatic cycle(output logic [N-1:0] rdy);
    logic [N-1:0] g;
    logic [4:0]   a;
    #1;
    g   = model_grant();
    rdy = bus.req_ready;
    check("req_ready", bus.req_ready, g);
    check("busy1", bus.busy1, m_sb[bus.chk_addr1]);
    check("busy2", bus.busy2, m_sb[bus.chk_addr2]);
    check("any_busy", bus.any_busy, |m_sb);
    @(posedge clk);
    m_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        a      = bus.req_addr[i*5 +: 5];
        m_en   = (a != 5'd0);
        m_addr = a;
        m_data = bus.req_data[i*32 +: 32];
        m_sb[a] = 1'b0;
        m_ptr  = (i + 1) % N;
      end
    end
    if (bus.claim_valid) m_sb[bus.claim_addr] = 1'b1;
    m_sb[0] = 1'b0;
    #1;
    check("rf_wr_en", bus.rf_wr_en, m_en);
    check("rf_wr_addr", bus.rf_wr_addr, m_addr);
    check("rf_wr_data", bus.rf_wr_data, m_data);
    if (!keep_valid) bus.req_valid = bus.req_valid & ~g;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", bus.rf_wr_en, 1'b0);
    check("rst_wr_addr", bus.rf_wr_addr, 5'd0);
    check("rst_wr_data", bus.rf_wr_data, 32'd0);
    check("rst_busy1", bus.busy1, 1'b0);
    check("rst_busy2", bus.busy2, 1'b0);
    check("rst_any_busy", bus.any_busy, 1'b0);
    check("rst_ready", bus.req_ready, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rdy;
    logic [N-1:0] exp_g;
    keep_valid = 1'b0;
    clear_inputs();
    model_reset();
    do_reset();

    // Single write
    set_req(1, 5'd5, 32'hDEADBEEF);
    cycle(rdy);
    check("single_ready", rdy, 3'b010);
    check("single_en", bus.rf_wr_en, 1'b1);
    check("single_addr", bus.rf_wr_addr, 5'd5);
    check("single_data", bus.rf_wr_data, 32'hDEADBEEF);
    cycle(rdy);
    check("single_en_drop", bus.rf_wr_en, 1'b0);

    // Contention from a fresh pointer
    do_reset();
    keep_valid = 1'b1;
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33);
    for (int k = 0; k < 6; k++) begin
      cycle(rdy);
`ifdef RF_WB_ROUND_ROBIN_EN
      exp_g = 3'b001 << (k % 3);
`else
      exp_g = 3'b001;
`endif
      check("contend", rdy, exp_g);
    end
    keep_valid = 1'b0;
    bus.req_valid = '0;

    // Scoreboard claim, clear, and simultaneous claim+clear
    bus.claim_valid = 1'b1;
    bus.claim_addr  = 5'd7;
    bus.chk_addr1   = 5'd7;
    cycle(rdy);
    bus.claim_valid = 1'b0;
    check("sb_claim", bus.busy1, 1'b1);
    set_req(2, 5'd7, 32'h7777);
    cycle(rdy);
    check("sb_clear", bus.busy1, 1'b0);
    set_req(2, 5'd7, 32'h7778);
    bus.claim_valid = 1'b1;
    cycle(rdy);
    bus.claim_valid = 1'b0;
    check("sb_set_wins", bus.busy1, 1'b1);

    // x0 write and claim
    set_req(0, 5'd0, 32'hABCD);
    bus.claim_valid = 1'b1;
    bus.claim_addr  = 5'd0;
    bus.chk_addr2   = 5'd0;
    cycle(rdy);
    bus.claim_valid = 1'b0;
    check("x0_ready", rdy, 3'b001);
    check("x0_en", bus.rf_wr_en, 1'b0);
    check("x0_busy", bus.busy2, 1'b0);

    // Stall holds requests off
    bus.stall_en = 1'b1;
    set_req(0, 5'd9, 32'h99);
    set_req(1, 5'd10, 32'hAA);
    repeat (2) begin
      cycle(rdy);
      check("stall_ready", rdy, 3'b000);
      check("stall_en_out", bus.rf_wr_en, 1'b0);
    end
    bus.stall_en = 1'b0;
    cycle(rdy);
`ifdef RF_WB_ROUND_ROBIN_EN
    check("unstall_ready", rdy, 3'b010);
`else
    check("unstall_ready", rdy, 3'b001);
`endif
    cycle(rdy);
    cycle(rdy);

    // Async reset while a write is on the pins and bits are busy
    bus.claim_valid = 1'b1;
    bus.claim_addr  = 5'd12;
    bus.chk_addr1   = 5'd12;
    cycle(rdy);
    bus.claim_valid = 1'b0;
    set_req(0, 5'd13, 32'h1313);
    cycle(rdy);
    check("pre_rst_en", bus.rf_wr_en, 1'b1);
    check("pre_rst_busy", bus.busy1, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_en", bus.rf_wr_en, 1'b0);
    check("async_rst_busy1", bus.busy1, 1'b0);
    check("async_rst_any", bus.any_busy, 1'b0);
    do_reset();

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          set_req(i, 5'($urandom_range(0, 7)), $urandom);
        end
      end
      bus.stall_en    = ($urandom_range(0, 4) == 0);
      bus.claim_valid = ($urandom_range(0, 2) == 0);
      bus.claim_addr  = 5'($urandom_range(0, 7));
      bus.chk_addr1   = 5'($urandom_range(0, 7));
      bus.chk_addr2   = 5'($urandom_range(0, 7));
      cycle(rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
